// File: rtl/tx_char_scheduler_if.sv
// tx_char_scheduler_if
//   Bundles the link-control, host, flow-control and encoder-side signals of
//   the transmit character scheduler.
//   master : drives permissions, host writes, FCT events and char_done;
//            observes the scheduled character and status.
//   slave  : the scheduler itself.
interface tx_char_scheduler_if;
  logic       enable_tx;
  logic       send_null;
  logic       send_fct_en;
  logic       send_nchar_en;
  logic       tickin_tx;
  logic [7:0] timecode_tx_i;
  logic       txwrite_tx;
  logic [8:0] data_tx_i;
  logic       fct_rx;
  logic       fct_send_req;
  logic       char_done;
  logic       txready_tx;
  logic       char_valid;
  logic [1:0] char_type;
  logic [8:0] char_data;
  logic [5:0] credit_cnt;
  logic [2:0] fct_pend_cnt;
  logic       credit_err;

  modport master (
    output enable_tx, send_null, send_fct_en, send_nchar_en,
           tickin_tx, timecode_tx_i, txwrite_tx, data_tx_i,
           fct_rx, fct_send_req, char_done,
    input  txready_tx, char_valid, char_type, char_data,
           credit_cnt, fct_pend_cnt, credit_err
  );

  modport slave (
    input  enable_tx, send_null, send_fct_en, send_nchar_en,
           tickin_tx, timecode_tx_i, txwrite_tx, data_tx_i,
           fct_rx, fct_send_req, char_done,
    output txready_tx, char_valid, char_type, char_data,
           credit_cnt, fct_pend_cnt, credit_err
  );
endinterface

// File: rtl/tx_char_scheduler.sv
// tx_char_scheduler
//   Chooses the next character for the link encoder (TIME > FCT > N-char >
//   NULL), tracks TX credits and owed FCTs, and holds a one-entry host buffer
//   and a pending time-code.
//   pclk_tx  : transmit clock
//   reset_tx : asynchronous active-high reset
//   bus      : scheduler interface (slave modport)
//
//   state  | meaning
//   IDLE   | link disabled or just enabled; nothing presented
//   PICK   | arbitrate; a winner is presented on the next edge
//   WAIT   | character presented, held until char_done
module tx_char_scheduler (
  input  logic                 pclk_tx,
  input  logic                 reset_tx,
  tx_char_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_WAIT} state_t;

  localparam logic [1:0] CT_NULL  = 2'd0;
  localparam logic [1:0] CT_FCT   = 2'd1;
  localparam logic [1:0] CT_NCHAR = 2'd2;
  localparam logic [1:0] CT_TIME  = 2'd3;
  localparam logic [6:0] CREDIT_MAX = 7'd56;

  state_t     state_q;
  logic       char_valid_q;
  logic [1:0] char_type_q;
  logic [8:0] char_data_q;
  logic [5:0] credit_q;
  logic [2:0] fct_pend_q;
  logic       credit_err_q;
  logic       buf_full_q;
  logic [8:0] buf_data_q;
  logic       tc_pend_q;
  logic [7:0] tc_val_q;

  logic       in_pick;
  logic       issue_time, issue_fct, issue_nchar, issue_null;
  logic [5:0] credit_dec;
  logic [6:0] credit_sum;
  logic       host_write;

  // Arbitration on registered state only; the winner is committed on the
  // next edge, which is also the edge that consumes its source.
  always_comb begin
    in_pick     = (state_q == S_PICK);
    issue_time  = in_pick && tc_pend_q && bus.send_nchar_en;
    issue_fct   = in_pick && !issue_time && (fct_pend_q != 3'd0) && bus.send_fct_en;
    issue_nchar = in_pick && !issue_time && !issue_fct && buf_full_q &&
                  (credit_q != 6'd0) && bus.send_nchar_en;
    issue_null  = in_pick && !issue_time && !issue_fct && !issue_nchar && bus.send_null;
    credit_dec  = credit_q - {5'd0, issue_nchar};
    credit_sum  = {1'b0, credit_dec} + 7'd8;
  end

  assign bus.txready_tx   = !buf_full_q && bus.enable_tx && !reset_tx;
  assign host_write       = bus.txwrite_tx && bus.txready_tx;
  assign bus.char_valid   = char_valid_q;
  assign bus.char_type    = char_type_q;
  assign bus.char_data    = char_data_q;
  assign bus.credit_cnt   = credit_q;
  assign bus.fct_pend_cnt = fct_pend_q;
  assign bus.credit_err   = credit_err_q;

  // Scheduler FSM with registered character outputs.
  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      state_q      <= S_IDLE;
      char_valid_q <= 1'b0;
      char_type_q  <= CT_NULL;
      char_data_q  <= 9'd0;
    end else if (!bus.enable_tx) begin
      // Flush aborts a character in flight without waiting for char_done.
      state_q      <= S_IDLE;
      char_valid_q <= 1'b0;
      char_type_q  <= CT_NULL;
      char_data_q  <= 9'd0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_PICK;
        S_PICK: begin
          if (issue_time || issue_fct || issue_nchar || issue_null) begin
            state_q      <= S_WAIT;
            char_valid_q <= 1'b1;
            if (issue_time) begin
              char_type_q <= CT_TIME;
              char_data_q <= {1'b0, tc_val_q};
            end else if (issue_fct) begin
              char_type_q <= CT_FCT;
              char_data_q <= 9'd0;
            end else if (issue_nchar) begin
              char_type_q <= CT_NCHAR;
              char_data_q <= buf_data_q;
            end else begin
              char_type_q <= CT_NULL;
              char_data_q <= 9'd0;
            end
          end
        end
        S_WAIT: begin
          if (bus.char_done) begin
            state_q      <= S_PICK;
            char_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sources: time-code, host buffer, credits, owed FCTs.
  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      tc_pend_q    <= 1'b0;
      tc_val_q     <= 8'd0;
      buf_full_q   <= 1'b0;
      buf_data_q   <= 9'd0;
      credit_q     <= 6'd0;
      credit_err_q <= 1'b0;
      fct_pend_q   <= 3'd0;
    end else if (!bus.enable_tx) begin
      tc_pend_q    <= 1'b0;
      tc_val_q     <= 8'd0;
      buf_full_q   <= 1'b0;
      buf_data_q   <= 9'd0;
      credit_q     <= 6'd0;
      credit_err_q <= 1'b0;
      fct_pend_q   <= 3'd0;
    end else begin
      // A tick on the issue edge re-arms pending with the new value.
      if (bus.tickin_tx) begin
        tc_pend_q <= 1'b1;
        tc_val_q  <= bus.timecode_tx_i;
      end else if (issue_time) begin
        tc_pend_q <= 1'b0;
      end

      if (issue_nchar) begin
        buf_full_q <= 1'b0;
      end else if (host_write) begin
        buf_full_q <= 1'b1;
        buf_data_q <= bus.data_tx_i;
      end

      // Overflowing grant is discarded; the same-edge decrement still applies.
      if (bus.fct_rx) begin
        if (credit_sum > CREDIT_MAX) begin
          credit_q     <= credit_dec;
          credit_err_q <= 1'b1;
        end else begin
          credit_q <= credit_sum[5:0];
        end
      end else begin
        credit_q <= credit_dec;
      end

      case ({bus.fct_send_req, issue_fct})
        2'b10:   if (fct_pend_q != 3'd7) fct_pend_q <= fct_pend_q + 3'd1;
        2'b01:   fct_pend_q <= fct_pend_q - 3'd1;
        default: fct_pend_q <= fct_pend_q;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_char_scheduler.sv
module tb_tx_char_scheduler;
  logic pclk_tx = 1'b0;
  logic reset_tx;
  int   n_assert = 0;
  int   n_fail   = 0;

  tx_char_scheduler_if bus ();

  tx_char_scheduler dut (
    .pclk_tx  (pclk_tx),
    .reset_tx (reset_tx),
    .bus      (bus.slave)
  );

  always #5 pclk_tx = ~pclk_tx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge pclk_tx);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic finish_char();
    bus.char_done = 1'b1;
    step();
    bus.char_done = 1'b0;
  endtask

  task automatic host_wr(input logic [8:0] d);
    bus.data_tx_i  = d;
    bus.txwrite_tx = 1'b1;
    step();
    bus.txwrite_tx = 1'b0;
  endtask

  task automatic flush_and_enable();
    bus.enable_tx = 1'b0;
    step();
    bus.enable_tx = 1'b1;
    step();
  endtask

  initial begin
    reset_tx = 1'b1;
    bus.enable_tx = 0; bus.send_null = 0; bus.send_fct_en = 0; bus.send_nchar_en = 0;
    bus.tickin_tx = 0; bus.timecode_tx_i = 0; bus.txwrite_tx = 0; bus.data_tx_i = 0;
    bus.fct_rx = 0; bus.fct_send_req = 0; bus.char_done = 0;
    step(); step();
    chk("rst_valid",  {8'd0, bus.char_valid}, 9'd0);
    chk("rst_credit", {3'd0, bus.credit_cnt}, 9'd0);
    chk("rst_fctp",   {6'd0, bus.fct_pend_cnt}, 9'd0);
    chk("rst_err",    {8'd0, bus.credit_err}, 9'd0);
    bus.enable_tx = 1'b1;
    step();
    chk("rst_txready_en", {8'd0, bus.txready_tx}, 9'd0);

    // NULL stream
    reset_tx = 1'b0;
    bus.send_null = 1'b1;
    step();
    chk("null_idle2pick", {8'd0, bus.char_valid}, 9'd0);
    step();
    chk("null1_valid", {8'd0, bus.char_valid}, 9'd1);
    chk("null1_type",  {7'd0, bus.char_type}, 9'd0);
    step();
    chk("null1_hold", {8'd0, bus.char_valid}, 9'd1);
    finish_char();
    chk("null_gap", {8'd0, bus.char_valid}, 9'd0);
    step();
    chk("null2_valid", {8'd0, bus.char_valid}, 9'd1);
    chk("null2_type",  {7'd0, bus.char_type}, 9'd0);
    finish_char();
    bus.send_null = 1'b0;

    // Credit grant and single N-char
    bus.fct_rx = 1'b1; step(); bus.fct_rx = 1'b0;
    chk("credit_8", {3'd0, bus.credit_cnt}, 9'd8);
    chk("txready_empty", {8'd0, bus.txready_tx}, 9'd1);
    host_wr(9'h041);
    chk("txready_full", {8'd0, bus.txready_tx}, 9'd0);
    host_wr(9'h055);
    chk("wr_ignored_valid", {8'd0, bus.char_valid}, 9'd0);
    bus.send_nchar_en = 1'b1;
    step();
    chk("nchar_type",  {7'd0, bus.char_type}, 9'd2);
    chk("nchar_data",  bus.char_data, 9'h041);
    chk("credit_7",    {3'd0, bus.credit_cnt}, 9'd7);
    chk("txready_after_issue", {8'd0, bus.txready_tx}, 9'd1);
    finish_char();
    bus.send_nchar_en = 1'b0;

    // Priority TIME > FCT > N-char > NULL
    bus.fct_send_req = 1'b1; step(); bus.fct_send_req = 1'b0;
    chk("fctp_1", {6'd0, bus.fct_pend_cnt}, 9'd1);
    host_wr(9'h100);
    bus.timecode_tx_i = 8'h12; bus.tickin_tx = 1'b1; step();
    bus.timecode_tx_i = 8'h3F; step();
    bus.tickin_tx = 1'b0;
    bus.send_null = 1'b1; bus.send_fct_en = 1'b1; bus.send_nchar_en = 1'b1;
    step();
    chk("prio_time_type", {7'd0, bus.char_type}, 9'd3);
    chk("prio_time_data", bus.char_data, 9'h03F);
    finish_char();
    step();
    chk("prio_fct_type", {7'd0, bus.char_type}, 9'd1);
    chk("prio_fct_data", bus.char_data, 9'h000);
    chk("fctp_0", {6'd0, bus.fct_pend_cnt}, 9'd0);
    finish_char();
    step();
    chk("prio_nchar_type", {7'd0, bus.char_type}, 9'd2);
    chk("prio_nchar_data", bus.char_data, 9'h100);
    chk("credit_6", {3'd0, bus.credit_cnt}, 9'd6);
    finish_char();
    step();
    chk("prio_null_type", {7'd0, bus.char_type}, 9'd0);
    finish_char();
    bus.send_null = 1'b0; bus.send_fct_en = 1'b0; bus.send_nchar_en = 1'b0;

    // Credit ceiling
    flush_and_enable();
    chk("flush_credit", {3'd0, bus.credit_cnt}, 9'd0);
    bus.fct_rx = 1'b1;
    repeat (7) step();
    bus.fct_rx = 1'b0;
    chk("credit_56", {3'd0, bus.credit_cnt}, 9'd56);
    chk("credit_56_noerr", {8'd0, bus.credit_err}, 9'd0);
    for (int i = 0; i < 7; i++) begin
      host_wr(9'h0A0 + 9'(i));
      bus.send_nchar_en = 1'b1; step(); bus.send_nchar_en = 1'b0;
      finish_char();
    end
    chk("credit_49", {3'd0, bus.credit_cnt}, 9'd49);
    host_wr(9'h0C3);
    bus.send_nchar_en = 1'b1; bus.fct_rx = 1'b1; step();
    bus.send_nchar_en = 1'b0; bus.fct_rx = 1'b0;
    chk("credit_net7", {3'd0, bus.credit_cnt}, 9'd56);
    chk("credit_net7_noerr", {8'd0, bus.credit_err}, 9'd0);
    finish_char();
    bus.fct_rx = 1'b1; step(); bus.fct_rx = 1'b0;
    chk("credit_ovf_hold", {3'd0, bus.credit_cnt}, 9'd56);
    chk("credit_ovf_err", {8'd0, bus.credit_err}, 9'd1);
    step();
    chk("credit_err_sticky", {8'd0, bus.credit_err}, 9'd1);

    // FCT owed counter saturation
    flush_and_enable();
    chk("flush_err", {8'd0, bus.credit_err}, 9'd0);
    bus.fct_send_req = 1'b1;
    repeat (8) step();
    chk("fctp_sat7", {6'd0, bus.fct_pend_cnt}, 9'd7);
    bus.send_fct_en = 1'b1;
    step();
    bus.fct_send_req = 1'b0;
    chk("fct_issue_type", {7'd0, bus.char_type}, 9'd1);
    chk("fctp_req_and_issue", {6'd0, bus.fct_pend_cnt}, 9'd7);
    finish_char();
    step();
    chk("fctp_dec6", {6'd0, bus.fct_pend_cnt}, 9'd6);
    finish_char();
    bus.send_fct_en = 1'b0;

    // No credit: NULLs only, then abort mid-WAIT
    flush_and_enable();
    host_wr(9'h077);
    bus.send_null = 1'b1; bus.send_nchar_en = 1'b1;
    step();
    chk("nocred_null1", {7'd0, bus.char_type}, 9'd0);
    chk("nocred_valid", {8'd0, bus.char_valid}, 9'd1);
    bus.timecode_tx_i = 8'h5A; bus.tickin_tx = 1'b1; step(); bus.tickin_tx = 1'b0;
    finish_char();
    step();
    chk("nocred_time_type", {7'd0, bus.char_type}, 9'd3);
    chk("nocred_time_data", bus.char_data, 9'h05A);
    finish_char();
    step();
    chk("nocred_null2", {7'd0, bus.char_type}, 9'd0);
    chk("nocred_credit0", {3'd0, bus.credit_cnt}, 9'd0);
    chk("nocred_bufheld", {8'd0, bus.txready_tx}, 9'd0);
    finish_char();
    step();
    bus.send_null = 1'b0;
    bus.timecode_tx_i = 8'h21; bus.tickin_tx = 1'b1; step(); bus.tickin_tx = 1'b0;
    finish_char();
    step();
    chk("abort_pre_data", bus.char_data, 9'h021);
    bus.enable_tx = 1'b0;
    step();
    chk("abort_valid", {8'd0, bus.char_valid}, 9'd0);
    chk("abort_type",  {7'd0, bus.char_type}, 9'd0);
    chk("abort_data",  bus.char_data, 9'd0);
    chk("abort_txready", {8'd0, bus.txready_tx}, 9'd0);
    bus.enable_tx = 1'b1;
    bus.send_nchar_en = 1'b0;
    step();
    chk("reenable_idle", {8'd0, bus.char_valid}, 9'd0);
    chk("reenable_txready", {8'd0, bus.txready_tx}, 9'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_char_scheduler.md
TX_CHAR_SCHEDULER -- requirements
Module: tx_char_scheduler

Interface
REQ-001 pclk_tx  in  1  transmit clock; all state updates on its rising edge.
REQ-002 reset_tx  in  1  asynchronous, active-high reset.
REQ-003 enable_tx  in  1  link enable; low = synchronous flush (see REQ-030).
REQ-004 send_null, send_fct_en, send_nchar_en  in  1 each  link-FSM permissions to emit NULL, FCT and N-char/time-code.
REQ-005 tickin_tx  in  1  time-code request pulse; timecode_tx_i  in  8  time-code value.
REQ-006 txwrite_tx  in  1  host write strobe; data_tx_i  in  9  host N-char (bit8=1: EOP/EEP).
REQ-007 fct_rx  in  1  pulse: FCT received from the peer, grants 8 credits.
REQ-008 fct_send_req  in  1  pulse: local RX buffer freed 8 slots, one FCT owed.
REQ-009 char_done  in  1  pulse from encoder: current character fully transmitted.
REQ-010 txready_tx  out  1  host may write this cycle.
REQ-011 char_valid  out  1  character presented to encoder.
REQ-012 char_type  out  2  0=NULL, 1=FCT, 2=N-char, 3=TIME.
REQ-013 char_data  out  9  N-char payload or {1'b0,time-code}; 0 for NULL/FCT.
REQ-014 credit_cnt  out  6  TX credits held, 0..56.
REQ-015 fct_pend_cnt  out  3  FCTs owed, 0..7.
REQ-016 credit_err  out  1  sticky credit-overflow flag.

Function
REQ-017 States IDLE, PICK, WAIT; IDLE->PICK when enable_tx=1.
REQ-018 PICK priority: TIME (pending, send_nchar_en) > FCT (fct_pend_cnt>0, send_fct_en) > N-char (buffer full, credit_cnt>0, send_nchar_en) > NULL (send_null).
REQ-019 PICK with a winner: next edge drives char_valid=1, char_type/char_data, state->WAIT; no winner: stay PICK, char_valid=0.
REQ-020 WAIT holds char_valid, char_type, char_data stable until char_done=1; that edge clears char_valid, state->PICK (one idle cycle between characters).
REQ-021 char_done outside WAIT ignored.
REQ-022 Time-code: tickin_tx=1 latches timecode_tx_i and sets pending; tick while pending overwrites value (newest wins); pending cleared on TIME issue edge; tick on that same edge re-sets pending with new value.
REQ-023 Data buffer: one entry; txready_tx = !buffer_full & enable_tx; txwrite_tx & txready_tx loads data_tx_i, sets full; txwrite_tx while !txready_tx ignored, buffer unchanged.
REQ-024 Buffer cleared on N-char issue edge; txready_tx rises the following cycle.
REQ-025 Credit: +8 on fct_rx, -1 on N-char issue edge; both same edge: net +7.
REQ-026 If credit_cnt+8 (after same-edge decrement) >56: credit_cnt keeps decrement-only value, credit_err set, held until reset_tx or enable_tx low.
REQ-027 N-char never issued when credit_cnt=0; credit_cnt never below 0.
REQ-028 fct_pend_cnt: +1 on fct_send_req (saturate at 7, request dropped), -1 on FCT issue edge; both same edge: unchanged.
REQ-029 Permission deasserted during WAIT does not abort current character.

Reset
REQ-030 reset_tx=1 (async) or enable_tx=0 (sync): state IDLE, char_valid=0, char_type=0, char_data=0, credit_cnt=0, fct_pend_cnt=0, credit_err=0, txready_tx=0, buffer empty, time-code pending cleared; enable_tx=0 mid-WAIT aborts without waiting for char_done.

Verification
REQ-031 Reset release, enable_tx=1, send_null=1 only -> PICK then char_valid=1, type 0; char_done each WAIT -> continuous NULLs with 1-cycle gaps.
REQ-032 fct_rx once, host writes 9'h041 with send_nchar_en=1 -> credit_cnt 8, N-char type 2 data 9'h041, credit_cnt 7, txready_tx high cycle after issue.
REQ-033 tickin_tx with 8'h3F, fct_pend_cnt=1, buffer full, all permissions -> order TIME(9'h03F), FCT, N-char.
REQ-034 Seven fct_rx pulses (56), then fct_rx -> credit_cnt stays 56, credit_err=1; fct_rx with simultaneous N-char at 49 -> 56, no error.
REQ-035 Eight fct_send_req with no FCT issue -> fct_pend_cnt saturates at 7; fct_send_req coinciding with FCT issue -> count unchanged.
REQ-036 credit_cnt=0, buffer full, send_null=1 -> NULLs only, no N-char; enable_tx=0 mid-WAIT -> next edge IDLE, all outputs 0.
